// File: rtl/v4_peak_detector_pkg.sv
// Shared widths, limits, FSM encoding and event record for the v4 peak detector.
package v4_peak_detector_pkg;
    localparam int SIZE_FILTER_DATA = 16;
    localparam int TS_WIDTH         = 32;
    localparam int HYST             = 10;
    localparam int MAX_WIDTH        = 64;
    localparam int LOST_WIDTH       = 16;
    localparam int CNT_W            = $clog2(MAX_WIDTH + 1);

    typedef logic [1:0] state_t;
    localparam state_t IDLE     = 2'd0;
    localparam state_t ACTIVE   = 2'd1;
    localparam state_t WAIT_LOW = 2'd2;

    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amplitude;
        logic [TS_WIDTH-1:0]                tstamp;
        logic                               pileup;
    } event_t;
endpackage

// File: rtl/v4_peak_detector_if.sv
// Event record output bus with valid/ready handshake and lost-event counter.
interface v4_peak_detector_if;
    import v4_peak_detector_pkg::*;

    logic                               peak_valid;
    logic                               peak_ready;
    logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude;
    logic [TS_WIDTH-1:0]                peak_time;
    logic                               peak_pileup;
    logic [LOST_WIDTH-1:0]              lost_count;

    modport master (
        output peak_valid, peak_amplitude, peak_time, peak_pileup, lost_count,
        input  peak_ready
    );

    modport slave (
        input  peak_valid, peak_amplitude, peak_time, peak_pileup, lost_count,
        output peak_ready
    );
endinterface

// File: rtl/v4_peak_detector_event_slot.sv
// Single-entry output register: accepts an event when empty or draining, else drops and counts it.
module v4_peak_detector_event_slot
    import v4_peak_detector_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               emit,
    input  event_t             ev,
    v4_peak_detector_if.master pk
);

    logic load;

    function automatic logic [LOST_WIDTH-1:0] sat_inc(input logic [LOST_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign load = emit && (!pk.peak_valid || pk.peak_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pk.peak_valid     <= 1'b0;
            pk.peak_amplitude <= '0;
            pk.peak_time      <= '0;
            pk.peak_pileup    <= 1'b0;
            pk.lost_count     <= '0;
        end else begin
            if (load) begin
                pk.peak_valid     <= 1'b1;
                pk.peak_amplitude <= ev.amplitude;
                pk.peak_time      <= ev.tstamp;
                pk.peak_pileup    <= ev.pileup;
            end else if (pk.peak_valid && pk.peak_ready) begin
                pk.peak_valid <= 1'b0;
            end
            if (emit && !load)
                pk.lost_count <= sat_inc(pk.lost_count);
        end
    end

endmodule

// File: rtl/v4_peak_detector.sv
// Threshold/hysteresis pulse detector: captures per-pulse maximum and its timestamp.
module v4_peak_detector
    import v4_peak_detector_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    v4_peak_detector_if.master                 pk
);

    localparam logic signed [SIZE_FILTER_DATA:0] HYST_X = (SIZE_FILTER_DATA+1)'(HYST);

    logic [TS_WIDTH-1:0]                ts;
    logic signed [SIZE_FILTER_DATA-1:0] d_p0;
    logic [TS_WIDTH-1:0]                ts_p0;

    state_t                             state_p1;
    logic signed [SIZE_FILTER_DATA-1:0] thr_p1;
    logic signed [SIZE_FILTER_DATA-1:0] max_p1;
    logic [TS_WIDTH-1:0]                max_ts_p1;
    logic [CNT_W-1:0]                   width_p1;

    logic signed [SIZE_FILTER_DATA:0]   thr_lo;
    logic signed [SIZE_FILTER_DATA:0]   d_x;
    logic                               arm, below, at_max_w, above_max;
    logic                               emit;
    event_t                             ev;

    // Extra bit keeps threshold - HYST from wrapping near the negative limit.
    assign thr_lo    = {thr_p1[SIZE_FILTER_DATA-1], thr_p1} - HYST_X;
    assign d_x       = {d_p0[SIZE_FILTER_DATA-1], d_p0};
    assign arm       = d_p0 > threshold;
    assign below     = d_x < thr_lo;
    assign at_max_w  = width_p1 == CNT_W'(MAX_WIDTH);
    assign above_max = d_p0 > max_p1;

    // Stage p0: free-running timestamp and input sample register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts    <= '0;
            d_p0  <= '0;
            ts_p0 <= '0;
        end else begin
            ts    <= ts + 1'b1;
            d_p0  <= filter_data;
            ts_p0 <= ts;
        end
    end

    // Stage p1: pulse FSM, running max and width counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p1  <= IDLE;
            thr_p1    <= '0;
            max_p1    <= '0;
            max_ts_p1 <= '0;
            width_p1  <= '0;
        end else begin
            case (state_p1)
                IDLE: begin
                    if (arm) begin
                        state_p1  <= ACTIVE;
                        thr_p1    <= threshold;
                        max_p1    <= d_p0;
                        max_ts_p1 <= ts_p0;
                        width_p1  <= CNT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (below) begin
                        state_p1 <= IDLE;
                    end else if (at_max_w) begin
                        state_p1 <= WAIT_LOW;
                    end else begin
                        width_p1 <= width_p1 + 1'b1;
                        if (above_max) begin
                            max_p1    <= d_p0;
                            max_ts_p1 <= ts_p0;
                        end
                    end
                end
                WAIT_LOW: begin
                    if (below)
                        state_p1 <= IDLE;
                end
                default: state_p1 <= IDLE;
            endcase
        end
    end

    always_comb begin
        emit = 1'b0;
        ev   = '{amplitude: max_p1, tstamp: max_ts_p1, pileup: 1'b0};
        if (state_p1 == ACTIVE) begin
            if (below) begin
                emit = 1'b1;
            end else if (at_max_w) begin
                emit      = 1'b1;
                ev.pileup = 1'b1;
            end
        end
    end

    // Stage p2: output event slot
    v4_peak_detector_event_slot u_slot (
        .clk   (clk),
        .reset (reset),
        .emit  (emit),
        .ev    (ev),
        .pk    (pk)
    );

endmodule

// File: tb/tb_v4_peak_detector.sv
// Directed bench for v4_peak_detector: threshold=100, HYST=10, MAX_WIDTH=64.
module tb_v4_peak_detector;
    import v4_peak_detector_pkg::*;

    logic                               clk = 1'b0;
    logic                               reset = 1'b0;
    logic signed [SIZE_FILTER_DATA-1:0] filter_data = '0;
    logic signed [SIZE_FILTER_DATA-1:0] threshold = SIZE_FILTER_DATA'(100);
    int                                 cyc;
    int                                 tests = 0;
    int                                 fails = 0;
    int                                 t;

    v4_peak_detector_if pk();

    v4_peak_detector dut (
        .clk         (clk),
        .reset       (reset),
        .filter_data (filter_data),
        .threshold   (threshold),
        .pk          (pk)
    );

    always #5 clk = ~clk;

    // Expected timestamp of a sample = clocks since reset release when it is driven.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int v);
        @(negedge clk);
        filter_data = SIZE_FILTER_DATA'(v);
    endtask

    // Called right after driving the ending sample.
    task automatic expect_event(input string tag, input int amp, input int ts_exp, input int pile);
        drive(0);
        chk({tag, "_early"}, 64'(pk.peak_valid), 64'd0);
        drive(0);
        chk({tag, "_valid"}, 64'(pk.peak_valid), 64'd1);
        chk({tag, "_amp"},   64'(pk.peak_amplitude), 64'(amp));
        chk({tag, "_time"},  64'(pk.peak_time), 64'(ts_exp));
        chk({tag, "_pile"},  64'(pk.peak_pileup), 64'(pile));
        drive(0);
        chk({tag, "_clear"}, 64'(pk.peak_valid), 64'd0);
    endtask

    initial begin
        pk.peak_ready = 1'b1;
        #12;
        chk("rst_valid", 64'(pk.peak_valid), 64'd0);
        chk("rst_amp",   64'(pk.peak_amplitude), 64'd0);
        chk("rst_time",  64'(pk.peak_time), 64'd0);
        chk("rst_pile",  64'(pk.peak_pileup), 64'd0);
        chk("rst_lost",  64'(pk.lost_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: trapezoid up to 500 with a 20-sample flat top
        for (int v = 0; v <= 450; v += 50) drive(v);
        drive(500);
        t = cyc;
        for (int i = 1; i < 20; i++) drive(500);
        for (int v = 450; v >= 100; v -= 50) drive(v);
        chk("t1_none_yet", 64'(pk.peak_valid), 64'd0);
        drive(50);
        expect_event("t1", 500, t, 0);

        // 2: edge values around threshold and hysteresis
        drive(100);
        drive(100);
        drive(101);
        t = cyc;
        drive(95);
        drive(90);
        drive(89);
        expect_event("t2", 101, t, 0);

        // 3: baseline never arms
        for (int i = 0; i < 4; i++) begin
            drive(-50);
            drive(0);
            drive(99);
        end
        drive(0);
        drive(0);
        chk("t3_valid", 64'(pk.peak_valid), 64'd0);
        chk("t3_lost",  64'(pk.lost_count), 64'd0);

        // 4: long plateau hits the width limit, then a normal pulse
        for (int j = 0; j < 100; j++) begin
            drive(200);
            if (j == 0) t = cyc;
            chk("t4_plateau_valid", 64'(pk.peak_valid), 64'(j == 66));
            if (j == 66) begin
                chk("t4_pile_amp",  64'(pk.peak_amplitude), 64'd200);
                chk("t4_pile_time", 64'(pk.peak_time), 64'(t));
                chk("t4_pile_flag", 64'(pk.peak_pileup), 64'd1);
            end
        end
        drive(0);
        for (int i = 0; i < 3; i++) begin
            drive(0);
            chk("t4_waitlow_quiet", 64'(pk.peak_valid), 64'd0);
        end
        drive(150);
        drive(300);
        t = cyc;
        drive(150);
        drive(0);
        expect_event("t4b", 300, t, 0);

        // 5: backpressure holds the first event and drops the second
        pk.peak_ready = 1'b0;
        drive(150);
        drive(300);
        t = cyc;
        drive(150);
        drive(0);
        drive(0);
        chk("t5_early", 64'(pk.peak_valid), 64'd0);
        drive(0);
        chk("t5_valid", 64'(pk.peak_valid), 64'd1);
        chk("t5_amp",   64'(pk.peak_amplitude), 64'd300);
        for (int i = 0; i < 3; i++) begin
            drive(0);
            chk("t5_hold_valid", 64'(pk.peak_valid), 64'd1);
            chk("t5_hold_amp",   64'(pk.peak_amplitude), 64'd300);
        end
        drive(200);
        drive(400);
        drive(200);
        drive(0);
        drive(0);
        drive(0);
        chk("t5_drop_valid", 64'(pk.peak_valid), 64'd1);
        chk("t5_drop_amp",   64'(pk.peak_amplitude), 64'd300);
        chk("t5_drop_time",  64'(pk.peak_time), 64'(t));
        chk("t5_lost",       64'(pk.lost_count), 64'd1);
        pk.peak_ready = 1'b1;
        drive(0);
        pk.peak_ready = 1'b0;
        chk("t5_xfer_clear", 64'(pk.peak_valid), 64'd0);
        drive(0);
        chk("t5_stay_clear", 64'(pk.peak_valid), 64'd0);
        chk("t5_lost_hold",  64'(pk.lost_count), 64'd1);

        // 6: asynchronous reset mid-pulse
        pk.peak_ready = 1'b1;
        drive(150);
        drive(300);
        @(posedge clk);
        #2;
        reset = 1'b0;
        filter_data = '0;
        #1;
        chk("t6_rst_valid", 64'(pk.peak_valid), 64'd0);
        chk("t6_rst_amp",   64'(pk.peak_amplitude), 64'd0);
        chk("t6_rst_time",  64'(pk.peak_time), 64'd0);
        chk("t6_rst_lost",  64'(pk.lost_count), 64'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0);
            chk("t6_no_event", 64'(pk.peak_valid), 64'd0);
        end
        drive(150);
        drive(250);
        t = cyc;
        drive(150);
        drive(0);
        expect_event("t6", 250, t, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/v4_peak_detector.md
Name: v4_peak_detector

Overview:
Consumer of the v4 trapezoidal shaper output. Takes one shaped sample per clock and detects pulses against a threshold with hysteresis. For each pulse it captures the maximum amplitude and its timestamp. Each result is one event record, offered downstream on a valid/ready handshake with a single-entry output register. Also flags pulses that stay above threshold too long, and counts events lost to backpressure.

Parameters:
SIZE_FILTER_DATA, from v4_parameters, width of the shaped sample (two's complement).
TS_WIDTH, 32, width of the free-running timestamp.
HYST, 10, hysteresis subtracted from the threshold for end-of-pulse detection.
MAX_WIDTH, 64, maximum pulse length in samples before the pile-up flag is set.
LOST_WIDTH, 16, width of the saturating lost-event counter.

Ports:
clk  in  1  system clock, one shaped sample per rising edge
reset  in  1  asynchronous, active-low reset
filter_data  in  SIZE_FILTER_DATA  shaped sample from v4_filter, signed
threshold  in  SIZE_FILTER_DATA  arming threshold, signed
peak_ready  in  1  downstream accepts the event
peak_valid  out  1  event record valid
peak_amplitude  out  SIZE_FILTER_DATA  maximum sample of the pulse
peak_time  out  TS_WIDTH  timestamp of the first maximum sample
peak_pileup  out  1  pulse was terminated by MAX_WIDTH
lost_count  out  LOST_WIDTH  number of events dropped while the output was full; saturates

Behaviour:
- Reset (asynchronous, reset==0) clears everything immediately:
  - all outputs = 0;
  - state = IDLE;
  - timestamp ts = 0;
  - input register, running max, width counter and latched threshold = 0.
- Reset mid-pulse discards the pulse; no event is produced.
- ts increments every clock and wraps modulo 2^TS_WIDTH.
- Input stage: d <= filter_data and ts_d <= ts each clock. The FSM operates on d and ts_d.
- All comparisons are signed. thr_lo = latched threshold - HYST, computed with one extra bit so it never wraps.
- IDLE:
  - If d > threshold (strict), go to ACTIVE.
  - On that transition: latch thr = threshold, max <= d, max_ts <= ts_d, width <= 1.
  - Changes on threshold during ACTIVE or WAIT_LOW have no effect until the next arm.
- ACTIVE, evaluated in this priority:
  - If d < thr_lo (strict): emit an event {max, max_ts, pileup=0}, next state IDLE. The ending sample is not compared for max.
  - Else if width == MAX_WIDTH: emit an event {max, max_ts, pileup=1}, next state WAIT_LOW.
  - Else: width++. If d > max (strict), update max and max_ts. Flat tops therefore report the first sample at the maximum.
- WAIT_LOW: stay until d < thr_lo, then go to IDLE. No event is produced.
- IDLE after an event: the next registered sample can re-arm immediately.
- Emit:
  - If !peak_valid, or peak_valid && peak_ready in the same cycle, load the output fields; peak_valid = 1 after that edge.
  - Otherwise the output fields are held unchanged, the new event is dropped, and lost_count increments (saturating at all-ones).
- Handshake:
  - peak_valid stays high and the fields stay stable until peak_valid && peak_ready.
  - On transfer with no new emit, peak_valid = 0 on the next edge.
  - peak_ready is ignored while peak_valid = 0.
- Latency: an ending sample presented on filter_data at edge E gives peak_valid high after edge E+1 (two clocks).
- ts wrap inside a pulse: peak_time is the raw wrapped value; no special handling.

Decomposition:
- v4_parameters gains TS_WIDTH, HYST, MAX_WIDTH and LOST_WIDTH defaults.
- v4_parameters also gains a typedef for the FSM state enum {IDLE, ACTIVE, WAIT_LOW}.
- v4_parameters also gains a packed event struct {amplitude, time, pileup}.
- One sub-module is natural: v4_event_slot, the single-entry valid/ready output register with drop and lost-count logic.

Test Plan:
All scenarios use threshold=100, HYST=10, MAX_WIDTH=64, peak_ready=1 unless stated.
1. Trapezoid 0, ramp 50/clk to 500, 20 samples flat at 500, ramp down to 0 -> exactly one event: amplitude=500, peak_time = ts of the first 500 sample, pileup=0, valid 2 clocks after the first sample <90.
2. Edge values 100,100,101,95,90,89 -> 100 does not arm; 101 arms; 90 does not end; 89 ends -> amplitude=101.
3. Negative or low baseline (-50, 0, 99 repeated) -> no event, state stays IDLE, lost_count=0.
4. Plateau at 200 for 100 samples, then 0, then a normal pulse peaking at 300:
   - first event pileup=1, amplitude=200, emitted at width 64;
   - no further event until a sample below 90;
   - then the second event: amplitude=300, pileup=0.
5. peak_ready=0 with two separated pulses (peaks 300, then 400):
   - the 300 event is held stable;
   - the 400 event is dropped and lost_count=1;
   - then peak_ready=1 for one clock -> transfer, peak_valid=0 next clock.
6. Assert reset for 1 clock mid-ACTIVE (asynchronously, between clock edges) -> outputs and ts are 0 immediately, no event for that pulse; after release, a new 250 pulse reports amplitude=250.
